// File: rtl/icache_pkg.sv
// Shared constants, address-split positions and FSM encoding for the
// 4-way set-associative instruction cache.
package icache_pkg;

    localparam int NUM_WAYS   = 4;
    localparam int NUM_SETS   = 8;
    localparam int LINE_WORDS = 8;
    localparam int TAG_W      = 24;

    localparam int DATA_W   = 32;
    localparam int WAY_W    = 2;
    localparam int INDEX_W  = 3;
    localparam int WORD_W   = 3;
    localparam int OFFSET_W = 5;
    localparam int LINE_W   = LINE_WORDS * DATA_W;

    localparam int WORD_LSB  = 2;
    localparam int INDEX_LSB = 5;
    localparam int TAG_LSB   = 8;

    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        LOOKUP   = 6'b000010,
        HIT_RSP  = 6'b000100,
        MISS_REQ = 6'b001000,
        REFILL   = 6'b010000,
        MISS_RSP = 6'b100000
    } state_e;

    function automatic logic [31:0] line_base(input logic [TAG_W-1:0] tag,
                                              input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and full 8-word line.
// Reads are combinational by index; a refill writes a whole line at once.
module icache_way
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line
);

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bit alone qualifies
    // them, which also keeps them mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Read-only 4-way instruction cache between the CPU fetch channels and a
// burst memory read channel; misses refill a whole line, FIFO replacement.
module inst_cache
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        from_cpu_inst_req_valid,
    input  logic [31:0] from_cpu_inst_req_addr,
    output logic        to_cpu_inst_req_ready,
    output logic        to_cpu_cache_rsp_valid,
    output logic [31:0] to_cpu_cache_rsp_data,
    input  logic        from_cpu_cache_rsp_ready,
    output logic        to_mem_rd_req_valid,
    output logic [31:0] to_mem_rd_req_addr,
    input  logic        from_mem_rd_req_ready,
    input  logic        from_mem_rd_rsp_valid,
    input  logic [31:0] from_mem_rd_rsp_data,
    input  logic        from_mem_rd_rsp_last,
    output logic        to_mem_rd_rsp_ready
);

    state_e                           state_q, state_d;
    logic [TAG_W-1:0]                 req_tag_q, req_tag_d;
    logic [INDEX_W-1:0]               req_index_q, req_index_d;
    logic [WORD_W-1:0]                req_word_q, req_word_d;
    logic                             req_ready_q, req_ready_d;
    logic                             rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]                rsp_data_q, rsp_data_d;
    logic                             mem_req_valid_q, mem_req_valid_d;
    logic [31:0]                      mem_req_addr_q, mem_req_addr_d;
    logic                             mem_rsp_ready_q, mem_rsp_ready_d;
    logic [WORD_W-1:0]                beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]                crit_q, crit_d;
    logic [DATA_W-1:0]                line_buf_q [LINE_WORDS];
    logic [DATA_W-1:0]                line_buf_d [LINE_WORDS];
    logic [NUM_SETS-1:0][WAY_W-1:0]   fifo_ptr_q, fifo_ptr_d;

    logic [NUM_WAYS-1:0] way_valid;
    logic [TAG_W-1:0]    way_tag  [NUM_WAYS];
    logic [LINE_W-1:0]   way_line [NUM_WAYS];
    logic [NUM_WAYS-1:0] way_wr_en;
    logic [LINE_W-1:0]   line_wdata;

    logic              hit;
    logic [DATA_W-1:0] hit_word;
    logic [WAY_W-1:0]  victim;
    logic              victim_from_ptr;
    logic              install;
    logic              beat;
    logic              addr_lsb_unused;

    // Byte-within-word bits never matter for a word-aligned fetch.
    assign addr_lsb_unused = ^from_cpu_inst_req_addr[WORD_LSB-1:0];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        icache_way u_way (
            .clk      (clk),
            .rst      (rst),
            .rd_index (req_index_q),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_line  (way_line[w]),
            .wr_en    (way_wr_en[w]),
            .wr_index (req_index_q),
            .wr_tag   (req_tag_q),
            .wr_line  (line_wdata)
        );
    end

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_valid[w] && (way_tag[w] == req_tag_q)) begin
                hit      = 1'b1;
                hit_word = way_line[w][{req_word_q, 5'd0} +: DATA_W];
            end
        end
    end

    // Lowest-index invalid way wins; only a full set consults the FIFO pointer.
    always_comb begin
        victim          = fifo_ptr_q[req_index_q];
        victim_from_ptr = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim          = WAY_W'(w);
                victim_from_ptr = 1'b0;
            end
        end
    end

    assign beat = mem_rsp_ready_q && from_mem_rd_rsp_valid;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        req_tag_d       = req_tag_q;
        req_index_d     = req_index_q;
        req_word_d      = req_word_q;
        req_ready_d     = req_ready_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_rsp_ready_d = mem_rsp_ready_q;
        beat_cnt_d      = beat_cnt_q;
        crit_d          = crit_q;
        line_buf_d      = line_buf_q;
        fifo_ptr_d      = fifo_ptr_q;
        install         = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (from_cpu_inst_req_valid && req_ready_q) begin
                    req_tag_d   = from_cpu_inst_req_addr[TAG_LSB +: TAG_W];
                    req_index_d = from_cpu_inst_req_addr[INDEX_LSB +: INDEX_W];
                    req_word_d  = from_cpu_inst_req_addr[WORD_LSB +: WORD_W];
                    req_ready_d = 1'b0;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = hit_word;
                    state_d     = HIT_RSP;
                end else begin
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = line_base(req_tag_q, req_index_q);
                    state_d         = MISS_REQ;
                end
            end
            HIT_RSP, MISS_RSP: begin
                if (from_cpu_cache_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            MISS_REQ: begin
                if (from_mem_rd_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    mem_rsp_ready_d = 1'b1;
                    state_d         = REFILL;
                end
            end
            REFILL: begin
                if (beat) begin
                    line_buf_d[beat_cnt_q] = from_mem_rd_rsp_data;
                    beat_cnt_d             = beat_cnt_q + WORD_W'(1);
                    if (beat_cnt_q == req_word_q) begin
                        crit_d = from_mem_rd_rsp_data;
                    end
                    if (from_mem_rd_rsp_last) begin
                        install    = 1'b1;
                        beat_cnt_d = '0;
                        if (victim_from_ptr) begin
                            fifo_ptr_d[req_index_q] = fifo_ptr_q[req_index_q] + WAY_W'(1);
                        end
                        mem_rsp_ready_d = 1'b0;
                        rsp_valid_d     = 1'b1;
                        // NOTE: blocking assignment here, so crit_d already
                        // holds a critical word that arrives on the last beat.
                        rsp_data_d      = crit_d;
                        state_d         = MISS_RSP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The installed line includes the beat arriving in the same cycle.
    always_comb begin
        line_wdata = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line_wdata[i*DATA_W +: DATA_W] = line_buf_d[i];
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_wr_en[w] = install && (victim == WAY_W'(w));
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            req_tag_q       <= '0;
            req_index_q     <= '0;
            req_word_q      <= '0;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_rsp_ready_q <= 1'b0;
            beat_cnt_q      <= '0;
            crit_q          <= '0;
            fifo_ptr_q      <= '0;
        end else begin
            state_q         <= state_d;
            req_tag_q       <= req_tag_d;
            req_index_q     <= req_index_d;
            req_word_q      <= req_word_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_rsp_ready_q <= mem_rsp_ready_d;
            beat_cnt_q      <= beat_cnt_d;
            crit_q          <= crit_d;
            fifo_ptr_q      <= fifo_ptr_d;
        end
    end

    // Partial refill data is meaningless after reset, so the buffer has none.
    always_ff @(posedge clk) begin
        line_buf_q <= line_buf_d;
    end

    assign to_cpu_inst_req_ready  = req_ready_q;
    assign to_cpu_cache_rsp_valid = rsp_valid_q;
    assign to_cpu_cache_rsp_data  = rsp_data_q;
    assign to_mem_rd_req_valid    = mem_req_valid_q;
    assign to_mem_rd_req_addr     = mem_req_addr_q;
    assign to_mem_rd_rsp_ready    = mem_rsp_ready_q;

endmodule

// File: tb/tb_inst_cache.sv
// Randomized self-checking bench for inst_cache: a set/way occupancy model
// predicts hits, misses and FIFO evictions; memory words derive from address.
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic        from_cpu_inst_req_valid;
    logic [31:0] from_cpu_inst_req_addr;
    logic        to_cpu_inst_req_ready;
    logic        to_cpu_cache_rsp_valid;
    logic [31:0] to_cpu_cache_rsp_data;
    logic        from_cpu_cache_rsp_ready;
    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready;
    logic        from_mem_rd_rsp_valid;
    logic [31:0] from_mem_rd_rsp_data;
    logic        from_mem_rd_rsp_last;
    logic        to_mem_rd_rsp_ready;

    inst_cache dut (
        .clk                      (clk),
        .rst                      (rst),
        .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
        .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
        .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
        .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
        .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
        .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
        .to_mem_rd_req_valid      (to_mem_rd_req_valid),
        .to_mem_rd_req_addr       (to_mem_rd_req_addr),
        .from_mem_rd_req_ready    (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] salt;

    // Reference model: which tags each set holds, plus its FIFO pointer.
    bit          m_valid [8][4];
    logic [23:0] m_tag   [8][4];
    int          m_ptr   [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return salt + {2'b00, a[31:2]};
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 0;
                m_tag[s][w]   = '0;
            end
        end
    endfunction

    function automatic bit model_hit(input int s, input logic [23:0] t);
        for (int w = 0; w < 4; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_fill(input int s, input logic [23:0] t);
        int v;
        v = -1;
        for (int w = 0; w < 4; w++) begin
            if (v < 0 && !m_valid[s][w]) v = w;
        end
        if (v < 0) begin
            v        = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % 4;
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = t;
    endfunction

    task automatic idle_inputs();
        from_cpu_inst_req_valid  = 1'b0;
        from_cpu_inst_req_addr   = '0;
        from_cpu_cache_rsp_ready = 1'b0;
        from_mem_rd_req_ready    = 1'b0;
        from_mem_rd_rsp_valid    = 1'b0;
        from_mem_rd_rsp_data     = '0;
        from_mem_rd_rsp_last     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(to_cpu_inst_req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(to_cpu_cache_rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, to_cpu_cache_rsp_data, 32'd0);
        check({tag, "_mem_req_valid"}, 32'(to_mem_rd_req_valid), 32'd0);
        check({tag, "_mem_rsp_ready"}, 32'(to_mem_rd_rsp_ready), 32'd0);
    endtask

    // Reset pulse; called at edge+1, returns at edge+1 with the cache idle.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("idle_after_reset", 32'(to_cpu_inst_req_ready), 32'd1);
    endtask

    // One fetch end to end; called and returns at edge+1. abort_beats >= 0
    // pulses reset after that many refill beats have transferred.
    task automatic fetch(input logic [31:0] addr, input int req_stall, input int rsp_stall,
                         input int max_gap, input int abort_beats);
        int          s, cyc, beats, gap, req_wait, rsp_wait, rsp_cyc;
        logic [23:0] t;
        logic [31:0] exp_data, base;
        bit          exp_hit, saw_req, refill, done, aborted, p_req, p_beat, p_rsp;

        s        = int'(addr[7:5]);
        t        = addr[31:8];
        base     = {addr[31:5], 5'b0};
        exp_hit  = model_hit(s, t);
        exp_data = mem_word(addr);
        cyc = 0; beats = 0; gap = 0; req_wait = 0; rsp_wait = 0; rsp_cyc = 0;
        saw_req = 0; refill = 0; done = 0; aborted = 0; p_req = 0; p_beat = 0; p_rsp = 0;

        from_cpu_inst_req_addr  = addr;
        from_cpu_inst_req_valid = 1'b1;
        while (!to_cpu_inst_req_ready && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("req_ready", 32'(to_cpu_inst_req_ready), 32'd1);
        @(posedge clk); #1;
        from_cpu_inst_req_valid = 1'b0;
        from_cpu_inst_req_addr  = $urandom;
        cyc = 1;

        while (!done && !aborted && cyc < 300) begin
            if (p_rsp) begin
                done = 1;
            end else begin
                if (p_req) refill = 1;
                if (p_beat) begin
                    beats++;
                    gap = int'($urandom_range(0, max_gap));
                end
                if (abort_beats >= 0 && beats == abort_beats) begin
                    aborted = 1;
                end else begin
                    from_mem_rd_req_ready = 1'b0;
                    if (saw_req && !refill) begin
                        check("mem_req_held", 32'(to_mem_rd_req_valid), 32'd1);
                    end
                    if (to_mem_rd_req_valid) begin
                        saw_req = 1;
                        check("mem_req_addr", to_mem_rd_req_addr, base);
                        from_mem_rd_req_ready = (req_wait >= req_stall);
                        req_wait++;
                    end

                    from_mem_rd_rsp_valid = 1'b0;
                    from_mem_rd_rsp_last  = 1'b0;
                    from_mem_rd_rsp_data  = $urandom;
                    if (refill && beats < 8) begin
                        if (gap > 0) begin
                            gap--;
                        end else begin
                            from_mem_rd_rsp_valid = 1'b1;
                            from_mem_rd_rsp_data  = mem_word(base + 32'(4 * beats));
                            from_mem_rd_rsp_last  = (beats == 7);
                        end
                    end

                    from_cpu_cache_rsp_ready = 1'b0;
                    if (rsp_cyc != 0) begin
                        check("rsp_valid_held", 32'(to_cpu_cache_rsp_valid), 32'd1);
                    end
                    if (to_cpu_cache_rsp_valid) begin
                        if (rsp_cyc == 0) begin
                            rsp_cyc = cyc;
                            if (exp_hit) check("hit_latency", 32'(rsp_cyc), 32'd2);
                            else         check("beats_before_rsp", 32'(beats), 32'd8);
                        end
                        check("rsp_data", to_cpu_cache_rsp_data, exp_data);
                        from_cpu_cache_rsp_ready = (rsp_wait >= rsp_stall);
                        rsp_wait++;
                    end

                    p_req  = to_mem_rd_req_valid && from_mem_rd_req_ready;
                    p_beat = from_mem_rd_rsp_valid && to_mem_rd_rsp_ready;
                    p_rsp  = to_cpu_cache_rsp_valid && from_cpu_cache_rsp_ready;
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        end

        idle_inputs();
        if (aborted) begin
            do_reset();
        end else begin
            check("fetch_done", 32'(done), 32'd1);
            check("hit_vs_model", 32'(!saw_req), 32'(exp_hit));
            check("rsp_valid_drop", 32'(to_cpu_cache_rsp_valid), 32'd0);
            if (!exp_hit) model_fill(s, t);
        end
    endtask

    initial begin
        logic [31:0] a;
        idle_inputs();
        model_reset();
        salt = 32'h100;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss, then a hit on the same line.
        fetch(32'h0000_0000, 0, 0, 0, -1);
        fetch(32'h0000_0004, 0, 0, 0, -1);

        // Critical word is the last beat of the burst.
        do_reset();
        salt = 32'h200;
        fetch(32'h0000_001C, 0, 0, 0, -1);

        // Five lines into set 0, then re-reads exercising FIFO eviction.
        do_reset();
        salt = 32'h100;
        for (int i = 0; i < 5; i++) fetch(32'(i) << 8, 0, 0, 0, -1);
        fetch(32'h0000_0000, 0, 0, 0, -1);
        fetch(32'h0000_0100, 0, 0, 0, -1);
        fetch(32'h0000_0300, 0, 0, 0, -1);
        fetch(32'h0000_0400, 0, 0, 0, -1);
        fetch(32'h0000_0200, 0, 0, 0, -1);

        // Backpressure on every channel.
        fetch(32'h0000_0528, 3, 4, 2, -1);
        fetch(32'h0000_052C, 0, 4, 0, -1);

        // Reset after three refill beats, then the same address misses again.
        fetch(32'h0000_0640, 1, 0, 1, 3);
        fetch(32'h0000_0640, 0, 0, 0, -1);
        fetch(32'h0000_0000, 0, 0, 0, -1);

        for (int i = 0; i < 200; i++) begin
            a = {24'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
